// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM state encoding and algorithm select.
package gcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REDUCE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_BIN = 1'b1;

   // Width of the binary-mode common power-of-two exponent.
   function automatic int k_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/gcd_engine_if.sv
// Request/acknowledge bundle between a GCD requester and the gcd_engine.
interface gcd_engine_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 9
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] y;
   logic             ack;
   logic             busy;
   logic [CNT_W-1:0] cycles;

   modport master (output start, mode, a, b, input y, ack, busy, cycles);
   modport slave  (input start, mode, a, b, output y, ack, busy, cycles);
endinterface

// File: rtl/gcd_step.sv
// One combinational reduction step of either subtractive Euclid or binary (Stein) GCD.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] z,
   input  logic             mode,
   output logic [WIDTH-1:0] x_next,
   output logic [WIDTH-1:0] z_next,
   output logic             k_inc,
   output logic             eq
);

   always_comb begin
      x_next = x;
      z_next = z;
      k_inc  = 1'b0;
      eq     = (x == z);
      if (mode == MODE_SUB) begin
         if (x > z) x_next = x - z;
         else       z_next = z - x;
      end else begin
         // Stein priority: shared factor of two first, then lone even operand, then odd-odd difference.
         if (!x[0] && !z[0]) begin
            x_next = x >> 1;
            z_next = z >> 1;
            k_inc  = 1'b1;
         end else if (!x[0]) begin
            x_next = x >> 1;
         end else if (!z[0]) begin
            z_next = z >> 1;
         end else if (x > z) begin
            x_next = (x - z) >> 1;
         end else begin
            z_next = (z - x) >> 1;
         end
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with start/ack four-phase handshake, zero-operand bypass and a saturating step counter.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 9
) (
   input logic         Clk,
   input logic         Rst,
   gcd_engine_if.slave bus
);

   localparam int K_W = k_width(WIDTH);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] x_reg, z_reg, y_reg;
   logic [K_W-1:0]   k_reg;
   logic             mode_reg;
   logic [CNT_W-1:0] cycles_reg;

   logic [WIDTH-1:0] x_step, z_step;
   logic             k_inc, eq;
   logic             zero_op;

   assign zero_op = (bus.a == '0) || (bus.b == '0);

   gcd_step #(.WIDTH(WIDTH)) u_step (
      .x      (x_reg),
      .z      (z_reg),
      .mode   (mode_reg),
      .x_next (x_step),
      .z_next (z_step),
      .k_inc  (k_inc),
      .eq     (eq)
   );

   always_ff @(posedge Clk) begin
      if (Rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (bus.start) state_next = zero_op ? ST_DONE : ST_REDUCE;
         ST_REDUCE: if (eq)        state_next = ST_DONE;
         ST_DONE:   if (!bus.start) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.ack    = (state_reg == ST_DONE);
      bus.busy   = (state_reg == ST_REDUCE);
      bus.y      = y_reg;
      bus.cycles = cycles_reg;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         x_reg      <= '0;
         z_reg      <= '0;
         k_reg      <= '0;
         mode_reg   <= MODE_SUB;
         y_reg      <= '0;
         cycles_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  x_reg      <= bus.a;
                  z_reg      <= bus.b;
                  mode_reg   <= bus.mode;
                  k_reg      <= '0;
                  cycles_reg <= '0;
                  // Zero operand: the answer is the other operand, available at the capture edge.
                  if (zero_op) y_reg <= bus.a | bus.b;
               end
            end
            ST_REDUCE: begin
               if (cycles_reg != '1) cycles_reg <= cycles_reg + 1'b1;
               if (eq) begin
                  y_reg <= x_reg << k_reg;
               end else begin
                  x_reg <= x_step;
                  z_reg <= z_step;
                  k_reg <= k_reg + {{(K_W-1){1'b0}}, k_inc};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: directed corner cases plus randomized pairs against an arithmetic GCD model.
module tb_gcd_engine;

   logic Clk = 1'b0;
   logic rst_m, rst_s;
   always #5 Clk = ~Clk;

   gcd_engine_if #(.WIDTH(16), .CNT_W(9)) mif ();
   gcd_engine_if #(.WIDTH(8),  .CNT_W(4)) sif ();

   gcd_engine #(.WIDTH(16), .CNT_W(9)) dut_main (.Clk(Clk), .Rst(rst_m), .bus(mif));
   gcd_engine #(.WIDTH(8),  .CNT_W(4)) dut_sat  (.Clk(Clk), .Rst(rst_s), .bus(sif));

   typedef struct {
      int unsigned y;
      int unsigned cyc;
   } exp_t;

   exp_t q_m[$];
   exp_t q_s[$];
   int   errors = 0;
   int   checks = 0;

   function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
      int unsigned t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Number of REDUCE cycles the rules prescribe, including the final equality cycle.
   function automatic int unsigned ref_steps(input int unsigned a, input int unsigned b, input bit m);
      int unsigned n = 0;
      if (a == 0 || b == 0) return 0;
      while (a != b) begin
         if (!m) begin
            if (a > b) a = a - b; else b = b - a;
         end else if (a % 2 == 0 && b % 2 == 0) begin
            a = a / 2; b = b / 2;
         end else if (a % 2 == 0) a = a / 2;
         else if (b % 2 == 0)     b = b / 2;
         else if (a > b)          a = (a - b) / 2;
         else                     b = (b - a) / 2;
         n++;
      end
      return n + 1;
   endfunction

   function automatic int unsigned sat(input int unsigned n, input int w);
      int unsigned mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic op_main(input int unsigned a, input int unsigned b, input bit m, input bit drop_early);
      int unsigned ey, es, lat;
      ey = ref_gcd(a, b);
      es = ref_steps(a, b, m);
      q_m.push_back('{ey, sat(es, 9)});
      mif.a = 16'(a); mif.b = 16'(b); mif.mode = m; mif.start = 1'b1;
      @(posedge Clk); #1;
      if (drop_early) begin
         mif.start = 1'b0;
         mif.a = 16'($urandom); mif.b = 16'($urandom); mif.mode = ~m;
      end
      chk("capture_ack", mif.ack, es == 0);
      chk("capture_busy", mif.busy, es != 0);
      lat = 0;
      while (!mif.ack && lat < 1000) begin
         @(posedge Clk); #1;
         lat++;
      end
      chk("latency", lat, es);
      if (drop_early) begin
         @(posedge Clk); #1;
         chk("ack_pulse", mif.ack, 0);
      end else begin
         @(posedge Clk); #1;
         chk("ack_hold", mif.ack, 1);
         chk("y_hold", mif.y, ey);
         mif.start = 1'b0;
         @(posedge Clk); #1;
         chk("ack_drop", mif.ack, 0);
      end
      chk("y_idle", mif.y, ey);
      $display("op main a=%0d b=%0d mode=%0d -> y=%0d cycles=%0d", a, b, m, mif.y, mif.cycles);
   endtask

   task automatic op_sat(input int unsigned a, input int unsigned b, input bit m);
      int unsigned es, lat;
      es = ref_steps(a, b, m);
      q_s.push_back('{ref_gcd(a, b), sat(es, 4)});
      sif.a = 8'(a); sif.b = 8'(b); sif.mode = m; sif.start = 1'b1;
      @(posedge Clk); #1;
      lat = 0;
      while (!sif.ack && lat < 1000) begin
         @(posedge Clk); #1;
         lat++;
      end
      chk("sat_latency", lat, es);
      sif.start = 1'b0;
      @(posedge Clk); #1;
      chk("sat_ack_drop", sif.ack, 0);
      $display("op sat a=%0d b=%0d mode=%0d -> y=%0d cycles=%0d", a, b, m, sif.y, sif.cycles);
   endtask

   initial begin
      int unsigned ra, rb, tries;
      bit rm;
      mif.start = 1'b0; mif.mode = 1'b0; mif.a = '0; mif.b = '0;
      sif.start = 1'b0; sif.mode = 1'b0; sif.a = '0; sif.b = '0;
      rst_m = 1'b1; rst_s = 1'b1;

      fork
         begin : monitor
            bit pm = 1'b0, ps = 1'b0;
            exp_t e;
            forever begin
               @(negedge Clk);
               if (mif.ack && !pm && !rst_m) begin
                  checks++;
                  if (q_m.size() == 0) begin
                     errors++;
                     $display("FAIL main_unexpected_ack: got y=%0d with no pending request", mif.y);
                  end else begin
                     checks--;
                     e = q_m.pop_front();
                     chk("main_y", mif.y, e.y);
                     chk("main_cycles", mif.cycles, e.cyc);
                  end
               end
               if (sif.ack && !ps && !rst_s) begin
                  checks++;
                  if (q_s.size() == 0) begin
                     errors++;
                     $display("FAIL sat_unexpected_ack: got y=%0d with no pending request", sif.y);
                  end else begin
                     checks--;
                     e = q_s.pop_front();
                     chk("sat_y", sif.y, e.y);
                     chk("sat_cycles", sif.cycles, e.cyc);
                  end
               end
               pm = mif.ack;
               ps = sif.ack;
            end
         end
      join_none

      repeat (3) @(posedge Clk);
      #1;
      rst_m = 1'b0; rst_s = 1'b0;
      chk("reset_ack", mif.ack, 0);
      chk("reset_busy", mif.busy, 0);
      chk("reset_y", mif.y, 0);
      chk("reset_cycles", mif.cycles, 0);
      chk("reset_sat_ack", sif.ack, 0);

      op_main(24, 10, 1'b0, 1'b0);
      op_main(48, 18, 1'b1, 1'b0);
      op_main(0, 33, 1'b0, 1'b0);
      op_main(0, 0, 1'b1, 1'b0);
      op_main(77, 77, 1'b0, 1'b0);
      op_main(77, 77, 1'b1, 1'b0);
      op_main(24, 10, 1'b1, 1'b1);
      op_main(45, 0, 1'b0, 1'b1);

      op_sat(255, 1, 1'b0);
      op_sat(255, 1, 1'b1);

      // Abort a long subtractive run with reset, then confirm a clean restart.
      mif.a = 16'd255; mif.b = 16'd1; mif.mode = 1'b0; mif.start = 1'b1;
      @(posedge Clk); #1;
      mif.start = 1'b0;
      repeat (10) @(posedge Clk);
      #1;
      chk("pre_reset_busy", mif.busy, 1);
      rst_m = 1'b1;
      @(posedge Clk); #1;
      rst_m = 1'b0;
      chk("midrst_ack", mif.ack, 0);
      chk("midrst_busy", mif.busy, 0);
      chk("midrst_y", mif.y, 0);
      chk("midrst_cycles", mif.cycles, 0);
      op_main(11, 33, 1'b0, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         rm = i[0];
         tries = 0;
         do begin
            ra = $urandom_range(65535);
            rb = $urandom_range(65535);
            if ($urandom_range(31) == 0) ra = 0;
            if ($urandom_range(31) == 0) rb = 0;
            tries++;
         end while (!rm && ref_steps(ra, rb, 1'b0) > 120 && tries < 50);
         if (!rm && ref_steps(ra, rb, 1'b0) > 120) rb = ra;
         op_main(ra, rb, rm, $urandom_range(3) == 0);
      end

      repeat (3) @(posedge Clk);
      #1;
      chk("main_queue_empty", q_m.size(), 0);
      chk("sat_queue_empty", q_s.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
